// File: rtl/song_pkg.sv
// Shared definitions for the song recorder: master-state encodings,
// recorder FSM states and payload word helpers.
package song_pkg;

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  localparam logic [1:0] ST_COMPOSE = 2'd2;
  localparam logic [1:0] ST_OVERDUB = 2'd3;

  // WAIT is the idle-wait state: a finished take parks here until the
  // master state leaves Compose/Overdub, so every take needs a fresh entry.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RECORD,
    S_OD_READ,
    S_OD_MERGE,
    S_TERMINATE,
    S_WAIT
  } rec_state_e;

  // The end-of-song marker always lives in the top bit of the RAM word.
  function automatic int end_bit_idx(input int payload_w);
    return payload_w - 1;
  endfunction

  // Builds a word at the widest supported size; callers cast it down to
  // their own payload width. The mask is expected to be zero-extended.
  function automatic logic [63:0] pack_payload(input logic end_bit,
                                               input logic [63:0] mask,
                                               input int payload_w);
    logic [63:0] w;
    logic [5:0]  idx;
    idx = 6'(payload_w - 1);
    w = mask;
    w[idx] = end_bit;
    return w;
  endfunction

endpackage

// File: rtl/beat_latch.sv
// Per-voice sticky latch: remembers any switch pressed since the last
// clear so presses shorter than a beat still reach the recorder.
module beat_latch #(
  parameter int NUM_VOICES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] switches,
  input  logic                  clear,
  output logic [NUM_VOICES-1:0] mask
);

  logic [NUM_VOICES-1:0] held_q;

  // Accumulate presses between beats; the clear cycle still sees live presses via the OR below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= '0;
    end else if (clear) begin
      held_q <= '0;
    end else begin
      held_q <= held_q | switches;
    end
  end

  assign mask = held_q | switches;

endmodule

// File: rtl/song_recorder.sv
// Song recorder: samples the voice mask on each beat and writes one word
// per beat into song RAM, in Compose (fresh take) or Overdub (merge) mode.
// Optional build macro SONG_RECORDER_LATCH_EN adds a sticky per-voice latch.
module song_recorder
  import song_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int ADDR_W     = 7,
  parameter int PAYLOAD_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] switches,
  input  logic                  beat,
  input  logic [1:0]            master_state,
  input  logic [PAYLOAD_W-1:0]  read_data,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [ADDR_W-1:0]     write_address,
  output logic [PAYLOAD_W-1:0]  write_payload,
  output logic                  start_recording,
  output logic                  finished_recording
);

  localparam int END_BIT = end_bit_idx(PAYLOAD_W);

  rec_state_e            state_q, state_d;
  logic [ADDR_W:0]       addr_q, addr_d;
  logic [PAYLOAD_W-1:0]  payload_q, payload_d;
  logic [NUM_VOICES-1:0] od_mask_q, od_mask_d;
  logic [NUM_VOICES-1:0] rec_mask;
  logic                  mode_active;
  logic                  overdub;
  logic                  at_last;
  logic                  past_end;
  logic                  unused_read_bits;

  assign mode_active = (master_state == ST_COMPOSE) || (master_state == ST_OVERDUB);
  assign overdub     = (master_state == ST_OVERDUB);
  assign at_last     = (addr_q[ADDR_W-1:0] == {ADDR_W{1'b1}});
  assign past_end    = addr_q[ADDR_W];

  // Only the end bit and the voice mask of a stored word are meaningful.
  assign unused_read_bits = ^read_data[PAYLOAD_W-2:NUM_VOICES];

`ifdef SONG_RECORDER_LATCH_EN
  beat_latch #(
    .NUM_VOICES(NUM_VOICES)
  ) u_beat_latch (
    .clk     (clk),
    .reset   (reset),
    .switches(switches),
    .clear   (beat | ~mode_active),
    .mask    (rec_mask)
  );
`else
  assign rec_mask = switches;
`endif

  function automatic logic [PAYLOAD_W-1:0] make_word(input logic e,
                                                     input logic [NUM_VOICES-1:0] m);
    return PAYLOAD_W'(pack_payload(e, 64'(m), PAYLOAD_W));
  endfunction

  // Registered FSM state, address counter, last written word and overdub mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      payload_q <= '0;
      od_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      payload_q <= payload_d;
      od_mask_q <= od_mask_d;
    end
  end

  // Next-state and strobe decode; Compose strobes follow beat in the same cycle,
  // a mode exit always takes priority over a coincident beat.
  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    payload_d          = payload_q;
    od_mask_d          = od_mask_q;
    read_enable        = 1'b0;
    write_enable       = 1'b0;
    start_recording    = 1'b0;
    finished_recording = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mode_active) begin
          state_d = S_ARMED;
          addr_d  = '0;
        end
      end

      S_ARMED: begin
        if (!mode_active) begin
          state_d = S_IDLE;
        end else if (beat) begin
          if (overdub) begin
            read_enable     = 1'b1;
            start_recording = 1'b1;
            od_mask_d       = rec_mask;
            state_d         = S_OD_MERGE;
          end else if (rec_mask != '0) begin
            write_enable    = 1'b1;
            start_recording = 1'b1;
            payload_d       = make_word(at_last, rec_mask);
            if (at_last) begin
              finished_recording = 1'b1;
              state_d            = S_WAIT;
            end else begin
              addr_d  = addr_q + (ADDR_W+1)'(1);
              state_d = S_RECORD;
            end
          end
        end
      end

      S_RECORD: begin
        if (!mode_active) begin
          state_d = S_TERMINATE;
        end else if (beat) begin
          write_enable = 1'b1;
          payload_d    = make_word(at_last, rec_mask);
          if (at_last) begin
            finished_recording = 1'b1;
            state_d            = S_WAIT;
          end else begin
            addr_d = addr_q + (ADDR_W+1)'(1);
          end
        end
      end

      // Overdub counterpart of RECORD: each beat issues the RAM read.
      S_OD_READ: begin
        if (!mode_active) begin
          state_d = S_TERMINATE;
        end else if (beat) begin
          read_enable = 1'b1;
          od_mask_d   = rec_mask;
          state_d     = S_OD_MERGE;
        end
      end

      // Read data is valid here; an exit abandons the in-flight merge.
      S_OD_MERGE: begin
        if (!mode_active) begin
          state_d = S_TERMINATE;
        end else begin
          write_enable = 1'b1;
          payload_d    = make_word(read_data[END_BIT],
                                   read_data[NUM_VOICES-1:0] | od_mask_q);
          if (read_data[END_BIT]) begin
            finished_recording = 1'b1;
            state_d            = S_WAIT;
          end else if (at_last) begin
            state_d = S_WAIT;
          end else begin
            addr_d  = addr_q + (ADDR_W+1)'(1);
            state_d = S_OD_READ;
          end
        end
      end

      S_TERMINATE: begin
        if (!past_end) begin
          write_enable       = 1'b1;
          finished_recording = 1'b1;
          payload_d          = make_word(1'b1, '0);
        end
        state_d = mode_active ? S_WAIT : S_IDLE;
      end

      S_WAIT: begin
        if (!mode_active) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign write_address = addr_q[ADDR_W-1:0];
  assign write_payload = write_enable ? payload_d : payload_q;

endmodule

// File: tb/tb_song_recorder.sv
// Directed self-checking bench for song_recorder (small RAM: ADDR_W=3).
module tb_song_recorder;

  logic        clk;
  logic        reset;
  logic [7:0]  switches;
  logic        beat;
  logic [1:0]  master_state;
  logic [15:0] read_data;
  logic        read_enable;
  logic        write_enable;
  logic [2:0]  write_address;
  logic [15:0] write_payload;
  logic        start_recording;
  logic        finished_recording;

  int checks;
  int fails;

  song_recorder #(
    .NUM_VOICES(8),
    .ADDR_W    (3),
    .PAYLOAD_W (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .switches          (switches),
    .beat              (beat),
    .master_state      (master_state),
    .read_data         (read_data),
    .read_enable       (read_enable),
    .write_enable      (write_enable),
    .write_address     (write_address),
    .write_payload     (write_payload),
    .start_recording   (start_recording),
    .finished_recording(finished_recording)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] ms, input logic [7:0] sw,
                               input logic bt, input logic [15:0] rd);
    master_state = ms;
    switches     = sw;
    beat         = bt;
    read_data    = rd;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [15:0] latch_exp;
    checks       = 0;
    fails        = 0;
    reset        = 1'b1;
    switches     = '0;
    beat         = 1'b0;
    master_state = 2'd0;
    read_data    = '0;
`ifdef SONG_RECORDER_LATCH_EN
    latch_exp = 16'h0008;
`else
    latch_exp = 16'h0000;
`endif

    #2;
    checkOutput("rst_we", 32'(write_enable), 32'h0);
    checkOutput("rst_re", 32'(read_enable), 32'h0);
    checkOutput("rst_addr", 32'(write_address), 32'h0);
    checkOutput("rst_payload", 32'(write_payload), 32'h0);
    checkOutput("rst_start", 32'(start_recording), 32'h0);
    checkOutput("rst_fin", 32'(finished_recording), 32'h0);
    cyc();
    cyc();
    reset = 1'b0;

    $display("[TB] compose start");
    applyStimulus(2, 8'h00, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, 8'h00, 1, 0);
      checkOutput("arm_no_write", 32'(write_enable), 32'h0);
      checkOutput("arm_no_start", 32'(start_recording), 32'h0);
      cyc();
      applyStimulus(2, 8'h00, 0, 0);
      cyc();
    end
    applyStimulus(2, 8'h05, 1, 0);
    checkOutput("start_we", 32'(write_enable), 32'h1);
    checkOutput("start_addr", 32'(write_address), 32'h0);
    checkOutput("start_payload", 32'(write_payload), 32'h0005);
    checkOutput("start_pulse", 32'(start_recording), 32'h1);
    cyc();
    applyStimulus(2, 8'h00, 0, 0);
    checkOutput("post_start_we", 32'(write_enable), 32'h0);
    checkOutput("post_start_addr", 32'(write_address), 32'h1);
    checkOutput("post_start_hold", 32'(write_payload), 32'h0005);
    cyc();

    $display("[TB] compose record and stop");
    begin
      logic [7:0] pats [4];
      pats = '{8'h11, 8'h22, 8'h80, 8'h3c};
      for (int k = 0; k < 4; k++) begin
        applyStimulus(2, pats[k], 1, 0);
        checkOutput("rec_we", 32'(write_enable), 32'h1);
        checkOutput("rec_addr", 32'(write_address), 32'(k + 1));
        checkOutput("rec_payload", 32'(write_payload), {24'h0, pats[k]});
        checkOutput("rec_no_start", 32'(start_recording), 32'h0);
        cyc();
        applyStimulus(2, 8'h00, 0, 0);
        cyc();
      end
    end
    applyStimulus(0, 8'hff, 1, 0);
    checkOutput("exit_wins_we", 32'(write_enable), 32'h0);
    cyc();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("term_we", 32'(write_enable), 32'h1);
    checkOutput("term_addr", 32'(write_address), 32'h5);
    checkOutput("term_payload", 32'(write_payload), 32'h8000);
    checkOutput("term_fin", 32'(finished_recording), 32'h1);
    cyc();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("after_term_we", 32'(write_enable), 32'h0);
    checkOutput("after_term_fin", 32'(finished_recording), 32'h0);
    checkOutput("after_term_hold", 32'(write_payload), 32'h8000);

    $display("[TB] overdub merge");
    applyStimulus(3, 8'h00, 0, 0);
    cyc();
    applyStimulus(3, 8'h02, 1, 0);
    checkOutput("od_re", 32'(read_enable), 32'h1);
    checkOutput("od_start", 32'(start_recording), 32'h1);
    checkOutput("od_no_we_beat", 32'(write_enable), 32'h0);
    checkOutput("od_addr0", 32'(write_address), 32'h0);
    cyc();
    applyStimulus(3, 8'h02, 0, 16'h0011);
    checkOutput("od_merge_we", 32'(write_enable), 32'h1);
    checkOutput("od_merge_addr", 32'(write_address), 32'h0);
    checkOutput("od_merge_payload", 32'(write_payload), 32'h0013);
    checkOutput("od_merge_fin", 32'(finished_recording), 32'h0);
    cyc();
    applyStimulus(3, 8'h00, 0, 0);
    checkOutput("od_idle_we", 32'(write_enable), 32'h0);
    checkOutput("od_addr1", 32'(write_address), 32'h1);
    cyc();
    applyStimulus(3, 8'h02, 1, 0);
    checkOutput("od_re2", 32'(read_enable), 32'h1);
    checkOutput("od_no_start2", 32'(start_recording), 32'h0);
    cyc();
    applyStimulus(3, 8'h02, 0, 16'h8000);
    checkOutput("od_end_we", 32'(write_enable), 32'h1);
    checkOutput("od_end_payload", 32'(write_payload), 32'h8002);
    checkOutput("od_end_fin", 32'(finished_recording), 32'h1);
    cyc();
    applyStimulus(3, 8'hff, 1, 0);
    checkOutput("wait_re", 32'(read_enable), 32'h0);
    checkOutput("wait_we", 32'(write_enable), 32'h0);
    cyc();
    applyStimulus(0, 8'h00, 0, 0);
    cyc();

    $display("[TB] async reset during merge");
    applyStimulus(3, 8'h00, 0, 0);
    cyc();
    applyStimulus(3, 8'h04, 1, 0);
    checkOutput("rst_od_re", 32'(read_enable), 32'h1);
    cyc();
    applyStimulus(3, 8'h04, 0, 16'h0001);
    checkOutput("rst_od_merge", 32'(write_payload), 32'h0005);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_we", 32'(write_enable), 32'h0);
    checkOutput("async_rst_payload", 32'(write_payload), 32'h0);
    checkOutput("async_rst_addr", 32'(write_address), 32'h0);
    cyc();
    reset = 1'b0;
    applyStimulus(3, 8'h04, 1, 0);
    checkOutput("post_rst_idle_re", 32'(read_enable), 32'h0);
    checkOutput("post_rst_idle_start", 32'(start_recording), 32'h0);
    cyc();
    applyStimulus(3, 8'h04, 1, 0);
    checkOutput("post_rst_armed_re", 32'(read_enable), 32'h1);
    cyc();
    applyStimulus(0, 8'h00, 0, 16'h0001);
    checkOutput("od_abandon_we", 32'(write_enable), 32'h0);
    cyc();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("od_term_payload", 32'(write_payload), 32'h8000);
    checkOutput("od_term_fin", 32'(finished_recording), 32'h1);
    cyc();

    $display("[TB] compose full");
    applyStimulus(2, 8'h00, 0, 0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2, 8'(i + 1), 1, 0);
      checkOutput("full_we", 32'(write_enable), 32'h1);
      checkOutput("full_addr", 32'(write_address), 32'(i));
      checkOutput("full_payload", 32'(write_payload), (i == 7) ? 32'h8008 : 32'(i + 1));
      checkOutput("full_fin", 32'(finished_recording), (i == 7) ? 32'h1 : 32'h0);
      cyc();
      applyStimulus(2, 8'h00, 0, 0);
      cyc();
    end
    applyStimulus(2, 8'hff, 1, 0);
    checkOutput("full_no_wrap_we", 32'(write_enable), 32'h0);
    checkOutput("full_no_wrap_fin", 32'(finished_recording), 32'h0);
    cyc();
    applyStimulus(0, 8'h00, 0, 0);
    cyc();

    $display("[TB] short press between beats");
    applyStimulus(2, 8'h00, 0, 0);
    cyc();
    applyStimulus(2, 8'h01, 1, 0);
    checkOutput("latch_first_payload", 32'(write_payload), 32'h0001);
    cyc();
    applyStimulus(2, 8'h08, 0, 0);
    cyc();
    applyStimulus(2, 8'h08, 0, 0);
    cyc();
    applyStimulus(2, 8'h00, 0, 0);
    cyc();
    applyStimulus(2, 8'h00, 1, 0);
    checkOutput("latch_we", 32'(write_enable), 32'h1);
    checkOutput("latch_addr", 32'(write_address), 32'h1);
    checkOutput("latch_payload", 32'(write_payload), 32'(latch_exp));
    cyc();
    applyStimulus(0, 8'h00, 0, 0);
    cyc();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("latch_term_addr", 32'(write_address), 32'h2);
    checkOutput("latch_term_fin", 32'(finished_recording), 32'h1);
    cyc();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
